// File: rtl/result_reader_pkg.sv
// result_reader_pkg -- shared configuration for the result reader block.
// Holds the default word/address widths, the skid buffer depth and the
// controller state encoding so the top, the interface and the bench agree.
package result_reader_pkg;

  localparam int RR_DATA_WIDTH = 8;
  localparam int RR_ADDR_SIZE  = 10;

  // Two entries cover the one-cycle RAM read latency at full rate.
  localparam int SKID_DEPTH    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2,
    ST_READ = 2'd3
  } rr_state_e;

endpackage

// File: rtl/result_reader_if.sv
// result_reader_if -- bus bundle between the convolution core / host and the
// result reader.
//   write side : result_addr, result_data, result_w_ena, result_w_vld, w_done
//   read cmd   : rd_start, rd_base, rd_len
//   read data  : o_rd_data, o_rd_valid, rd_ready, o_rd_last
//   status     : o_buf_ready, o_rd_busy, o_rd_done, o_wr_err
// Modports: slave = the reader, master = the core/host side.
interface result_reader_if
  import result_reader_pkg::*;
#(
  parameter int DATA_WIDTH = RR_DATA_WIDTH,
  parameter int ADDR_SIZE  = RR_ADDR_SIZE
);
  logic [ADDR_SIZE-1:0]  result_addr;
  logic [DATA_WIDTH-1:0] result_data;
  logic                  result_w_ena;
  logic                  result_w_vld;
  logic                  w_done;
  logic                  rd_start;
  logic [ADDR_SIZE-1:0]  rd_base;
  logic [ADDR_SIZE:0]    rd_len;
  logic                  rd_ready;
  logic                  o_buf_ready;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_rd_valid;
  logic                  o_rd_last;
  logic                  o_rd_busy;
  logic                  o_rd_done;
  logic                  o_wr_err;

  modport slave (
    input  result_addr, result_data, result_w_ena, result_w_vld, w_done,
           rd_start, rd_base, rd_len, rd_ready,
    output o_buf_ready, o_rd_data, o_rd_valid, o_rd_last, o_rd_busy,
           o_rd_done, o_wr_err
  );

  modport master (
    output result_addr, result_data, result_w_ena, result_w_vld, w_done,
           rd_start, rd_base, rd_len, rd_ready,
    input  o_buf_ready, o_rd_data, o_rd_valid, o_rd_last, o_rd_busy,
           o_rd_done, o_wr_err
  );
endinterface

// File: rtl/result_reader_ram.sv
// result_ram -- simple dual-port result buffer, depth 2**ADDR_SIZE.
//   clk              : rising-edge clock
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr     : read request, o_rdata valid one cycle later
// Contents are not reset.
module result_ram
  import result_reader_pkg::*;
#(
  parameter int DATA_WIDTH = RR_DATA_WIDTH,
  parameter int ADDR_SIZE  = RR_ADDR_SIZE
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_SIZE-1:0]  i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_SIZE-1:0]  i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/result_reader.sv
// result_reader -- collects result words from the convolution core into a
// buffer, then streams a requested address window to the host.
//   clk, rst : clock, synchronous active-high reset
//   bus      : result_reader_if.slave (write bus, read command, read stream,
//              status flags)
//   o_wr_count (only with RESULT_READER_CNT_EN): accepted writes in the
//              current fill, saturating at 2**ADDR_SIZE
// Read path: address issue -> RAM register -> 2-entry skid -> o_rd_data.
module result_reader
  import result_reader_pkg::*;
#(
  parameter int DATA_WIDTH = RR_DATA_WIDTH,
  parameter int ADDR_SIZE  = RR_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  result_reader_if.slave       bus
`ifdef RESULT_READER_CNT_EN
  ,
  output logic [ADDR_SIZE:0]   o_wr_count
`endif
);
  localparam logic [ADDR_SIZE:0] ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

  rr_state_e             r_state, w_state_nxt;
  logic                  w_wr_try, w_wr_acc, w_pop, w_last_pop, w_start, w_issue;
  logic [ADDR_SIZE-1:0]  r_rd_addr;
  logic [ADDR_SIZE:0]    r_issue_left, r_beat_left;
  logic                  r_q_vld, r_done, r_wr_err;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic [DATA_WIDTH-1:0] r_skid [SKID_DEPTH];
  logic [1:0]            r_cnt;
  logic [2:0]            w_occ, w_cap;

  assign w_wr_try   = bus.result_w_ena & bus.result_w_vld;
  assign w_wr_acc   = w_wr_try & (r_state != ST_READ);
  assign w_pop      = (r_cnt != 2'd0) & bus.rd_ready;
  assign w_last_pop = w_pop & (r_beat_left == ONE);
  // A write in FULL starts a new result set and wins over a read request.
  assign w_start    = (r_state == ST_FULL) & bus.rd_start & ~w_wr_acc;

  // Issue only if the word landing next cycle is guaranteed a skid slot:
  // skid + in-flight RAM word, less what leaves this cycle, must be < depth.
  assign w_occ   = {1'b0, r_cnt} + {2'b0, r_q_vld};
  assign w_cap   = 3'(SKID_DEPTH) + {2'b0, w_pop};
  assign w_issue = (r_state == ST_READ) & (r_issue_left != '0) & (w_occ < w_cap);

  result_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_SIZE(ADDR_SIZE)) u_ram (
    .clk    (clk),
    .i_we   (w_wr_acc),
    .i_waddr(bus.result_addr),
    .i_wdata(bus.result_data),
    .i_re   (w_issue),
    .i_raddr(r_rd_addr),
    .o_rdata(w_ram_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.w_done) w_state_nxt = ST_FULL;
               else if (w_wr_acc) w_state_nxt = ST_FILL;
      ST_FILL: if (bus.w_done) w_state_nxt = ST_FULL;
      ST_FULL: if (w_wr_acc) w_state_nxt = bus.w_done ? ST_FULL : ST_FILL;
               else if (w_start && bus.rd_len != '0) w_state_nxt = ST_READ;
      ST_READ: if (w_last_pop) w_state_nxt = ST_FULL;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_q_vld      <= 1'b0;
      r_cnt        <= 2'd0;
      r_done       <= 1'b0;
      r_wr_err     <= 1'b0;
      r_rd_addr    <= '0;
      r_issue_left <= '0;
      r_beat_left  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_q_vld <= w_issue;
      // Zero-length request completes immediately with no beats.
      r_done  <= (w_start & (bus.rd_len == '0)) | w_last_pop;
      if (w_wr_try && r_state == ST_READ) r_wr_err <= 1'b1;
      if (w_start) begin
        r_rd_addr    <= bus.rd_base;
        r_issue_left <= bus.rd_len;
        r_beat_left  <= bus.rd_len;
      end else begin
        if (w_issue) begin
          r_rd_addr    <= r_rd_addr + 1'b1;    // wraps at buffer top
          r_issue_left <= r_issue_left - 1'b1;
        end
        if (w_pop) r_beat_left <= r_beat_left - 1'b1;
      end
      case ({r_q_vld, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Skid data: entry 0 is the head; a push lands behind whatever survives.
  always_ff @(posedge clk) begin
    if (w_pop) r_skid[0] <= r_skid[1];
    if (r_q_vld) begin
      if (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)) r_skid[0] <= w_ram_q;
      else r_skid[1] <= w_ram_q;
    end
  end

  assign bus.o_rd_valid  = (r_cnt != 2'd0);
  assign bus.o_rd_data   = bus.o_rd_valid ? r_skid[0] : '0;
  assign bus.o_rd_last   = bus.o_rd_valid & (r_beat_left == ONE);
  assign bus.o_rd_busy   = (r_state == ST_READ);
  assign bus.o_buf_ready = (r_state == ST_FULL);
  assign bus.o_rd_done   = r_done;
  assign bus.o_wr_err    = r_wr_err;

`ifdef RESULT_READER_CNT_EN
  localparam logic [ADDR_SIZE:0] CNT_MAX = {1'b1, {ADDR_SIZE{1'b0}}};
  logic [ADDR_SIZE:0] r_wr_count;

  // The write that opens a new set counts as its first.
  always_ff @(posedge clk) begin
    if (rst) r_wr_count <= '0;
    else if (w_wr_acc) begin
      if (r_state == ST_IDLE || r_state == ST_FULL) r_wr_count <= ONE;
      else if (r_wr_count != CNT_MAX) r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign o_wr_count = r_wr_count;
`endif
endmodule

// File: tb/tb_result_reader.sv
module tb_result_reader;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk, rst;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] mem_m [DEPTH];

  result_reader_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) bus ();
`ifdef RESULT_READER_CNT_EN
  logic [AW:0] wr_count;
`endif

  result_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RESULT_READER_CNT_EN
    , .o_wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic wr(input int a, input int d, input bit done);
    bus.result_w_ena = 1; bus.result_w_vld = 1;
    bus.result_addr = AW'(a); bus.result_data = DW'(d); bus.w_done = done;
    mem_m[a] = DW'(d);
    @(negedge clk);
    bus.result_w_ena = 0; bus.result_w_vld = 0; bus.w_done = 0;
  endtask

  // mode 0: rd_ready always high, 1: pattern 1,0,0 repeating, 2: random.
  // inj: attempt a write (plus w_done) to rd_base while the read runs.
  task automatic do_read(input int base, input int len, input int mode, input bit inj);
    logic [DW-1:0] expq[$];
    logic [DW-1:0] pd;
    logic pl, pstall, seen;
    int k, got, ph;
    for (int i = 0; i < len; i++) expq.push_back(mem_m[(base + i) % DEPTH]);
    bus.rd_start = 1; bus.rd_base = AW'(base); bus.rd_len = (AW+1)'(len);
    @(negedge clk);
    bus.rd_start = 0;
    k = 1; got = 0; ph = 0; pstall = 0; seen = 0; pd = '0; pl = 0;
    while (got < len && k < 200) begin
      case (mode)
        0: bus.rd_ready = 1;
        1: bus.rd_ready = (ph % 3 == 0);
        default: bus.rd_ready = ($urandom_range(0, 2) != 0);
      endcase
      ph++;
      if (inj) begin
        if (k == 2) begin
          bus.result_w_ena = 1; bus.result_w_vld = 1; bus.w_done = 1;
          bus.result_addr = AW'(base); bus.result_data = ~expq[0];
        end else begin
          bus.result_w_ena = 0; bus.result_w_vld = 0; bus.w_done = 0;
        end
      end
      if (pstall)
        chk("stall_hold", 32'({bus.o_rd_valid, bus.o_rd_last, bus.o_rd_data}),
            32'({1'b1, pl, pd}));
      if (bus.o_rd_valid && !seen) begin
        chk("first_valid_lat", 32'(k), 32'd3);
        seen = 1;
      end
      if (bus.o_rd_valid && bus.rd_ready) begin
        chk("rd_data", 32'(bus.o_rd_data), 32'(expq[got]));
        chk("rd_last", 32'(bus.o_rd_last), 32'(got == len - 1));
        if (mode == 0) chk("burst_cycle", 32'(k), 32'(3 + got));
        got++;
      end
      pstall = bus.o_rd_valid && !bus.rd_ready;
      pd = bus.o_rd_data; pl = bus.o_rd_last;
      @(negedge clk);
      k++;
    end
    bus.rd_ready = 0;
    bus.result_w_ena = 0; bus.result_w_vld = 0; bus.w_done = 0;
    chk("rd_beats", 32'(got), 32'(len));
    chk("rd_done_pulse", 32'(bus.o_rd_done), 32'd1);
    chk("busy_after", 32'(bus.o_rd_busy), 32'd0);
    chk("bufrdy_after", 32'(bus.o_buf_ready), 32'd1);
    chk("valid_after", 32'(bus.o_rd_valid), 32'd0);
    @(negedge clk);
    chk("rd_done_end", 32'(bus.o_rd_done), 32'd0);
  endtask

  initial begin
    int n, a, got, k;
    logic any_v;
    clk = 0; rst = 1;
    bus.result_addr = '0; bus.result_data = '0; bus.result_w_ena = 0;
    bus.result_w_vld = 0; bus.w_done = 0; bus.rd_start = 0;
    bus.rd_base = '0; bus.rd_len = '0; bus.rd_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'({bus.o_buf_ready, bus.o_rd_valid, bus.o_rd_last, bus.o_rd_busy,
                            bus.o_rd_done, bus.o_wr_err, bus.o_rd_data}), 32'd0);
    rst = 0;
    @(negedge clk);

    // Basic fill and full-rate read
    wr(0, 5, 0); wr(1, 6, 0); wr(2, 7, 0); wr(3, 8, 0);
    bus.w_done = 1; @(negedge clk); bus.w_done = 0;
    chk("buf_ready_full", 32'(bus.o_buf_ready), 32'd1);
    chk("wr_err_clean", 32'(bus.o_wr_err), 32'd0);
`ifdef RESULT_READER_CNT_EN
    chk("wr_count4", 32'(wr_count), 32'd4);
`endif
    do_read(0, 4, 0, 0);
    do_read(0, 4, 1, 0);

    // Enable without valid is not a write: stays FULL
    bus.result_w_ena = 1; bus.result_addr = 4'd1; bus.result_data = 8'hEE;
    @(negedge clk);
    bus.result_w_ena = 0;
    chk("ena_no_vld", 32'(bus.o_buf_ready), 32'd1);

    // Wrap-around read; last write shares its cycle with w_done
    wr(14, 1, 0);
    chk("fill_not_ready", 32'(bus.o_buf_ready), 32'd0);
    wr(15, 2, 0);
    wr(0, 3, 1);
    chk("wr_done_same", 32'(bus.o_buf_ready), 32'd1);
    do_read(14, 3, 0, 0);

    // Write during READ is dropped and flagged
    do_read(0, 4, 2, 1);
    chk("wr_err_set", 32'(bus.o_wr_err), 32'd1);
    do_read(0, 4, 0, 0);

    // Zero-length read
    bus.rd_start = 1; bus.rd_base = '0; bus.rd_len = '0;
    @(negedge clk);
    bus.rd_start = 0;
    chk("len0_done", 32'({bus.o_rd_done, bus.o_rd_valid, bus.o_rd_busy, bus.o_buf_ready}), 32'b1001);
    @(negedge clk);
    chk("len0_after", 32'({bus.o_rd_done, bus.o_rd_valid, bus.o_buf_ready}), 32'b001);

    // Reset at the second beat of a 4-beat read
    bus.rd_start = 1; bus.rd_base = '0; bus.rd_len = 5'd4;
    @(negedge clk);
    bus.rd_start = 0; bus.rd_ready = 1;
    got = 0; k = 0;
    while (got < 2 && k < 20) begin
      if (bus.o_rd_valid) got++;
      if (got < 2) begin @(negedge clk); k++; end
    end
    chk("rst_mid_reach", 32'(got), 32'd2);
    rst = 1;
    @(negedge clk);
    rst = 0; bus.rd_ready = 0;
    chk("rst_mid_outputs", 32'({bus.o_buf_ready, bus.o_rd_valid, bus.o_rd_last, bus.o_rd_busy,
                                bus.o_rd_done, bus.o_wr_err, bus.o_rd_data}), 32'd0);
    // rd_start in IDLE is ignored
    bus.rd_start = 1; bus.rd_len = 5'd2;
    @(negedge clk);
    bus.rd_start = 0; bus.rd_ready = 1; any_v = 0;
    repeat (5) begin any_v |= bus.o_rd_valid | bus.o_rd_busy; @(negedge clk); end
    bus.rd_ready = 0;
    chk("idle_rd_ignored", 32'(any_v), 32'd0);
    // Empty result set still completes
    bus.w_done = 1; @(negedge clk); bus.w_done = 0;
    chk("idle_wdone_full", 32'(bus.o_buf_ready), 32'd1);

    // Randomised fills and reads; first pass defines every word again
    for (int it = 0; it < 6; it++) begin
      n = (it == 0) ? DEPTH : int'($urandom_range(2, 6));
      for (int j = 0; j < n; j++) begin
        a = (it == 0) ? j : int'($urandom_range(0, DEPTH - 1));
        wr(a, int'($urandom_range(0, 255)), j == n - 1);
      end
      chk("rand_full", 32'(bus.o_buf_ready), 32'd1);
`ifdef RESULT_READER_CNT_EN
      chk("rand_count", 32'(wr_count), 32'(n));
`endif
      do_read(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one stored result word.
REQ-002 Parameter ADDR_SIZE, default 10, result address width; buffer depth = 2**ADDR_SIZE.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 result_addr  input  ADDR_SIZE  write address from the convolution core.
REQ-006 result_data  input  DATA_WIDTH  shifted, saturated result word.
REQ-007 result_w_ena  input  1  write enable; result_w_vld  input  1  write data valid.
REQ-008 w_done  input  1  one-cycle pulse, core finished all result writes.
REQ-009 rd_start  input  1  host read request; rd_base  input  ADDR_SIZE  first address; rd_len  input  ADDR_SIZE+1  word count.
REQ-010 o_buf_ready  output  1  buffer complete and readable.
REQ-011 o_rd_data  output  DATA_WIDTH; o_rd_valid  output  1; rd_ready  input  1; o_rd_last  output  1  final beat.
REQ-012 o_rd_busy  output  1  read in progress; o_rd_done  output  1  one-cycle pulse after last accepted beat.
REQ-013 o_wr_err  output  1  sticky, write arrived while reading.

Function
REQ-014 Write accepted iff result_w_ena && result_w_vld and state is not READ; mem[result_addr] <= result_data on that edge.
REQ-015 FSM states IDLE, FILL, FULL, READ; IDLE->FILL on first accepted write; FILL->FULL on w_done; FULL->FILL on new accepted write; FULL->READ on rd_start with rd_len!=0; READ->FULL after last beat accepted.
REQ-016 w_done in IDLE moves to FULL (empty result set is still a completed result set).
REQ-017 o_buf_ready = 1 in FULL only; o_rd_busy = 1 in READ only.
REQ-018 rd_start outside FULL ignored; rd_start with rd_len==0 in FULL produces o_rd_done pulse next cycle, no beats, state stays FULL.
REQ-019 Read address sequence rd_base, rd_base+1, ... modulo 2**ADDR_SIZE (wraps at top of buffer).
REQ-020 First o_rd_valid exactly 2 cycles after the rd_start edge (1 cycle address issue, 1 cycle synchronous RAM).
REQ-021 Beat transfers when o_rd_valid && rd_ready; with rd_ready held high, one beat per cycle sustained.
REQ-022 While o_rd_valid && !rd_ready, o_rd_data and o_rd_last stable; 2-entry skid buffer absorbs RAM pipeline, no beat lost or duplicated.
REQ-023 o_rd_last high only with the rd_len-th beat.
REQ-024 Write attempt in READ: discarded, o_wr_err set; simultaneous w_done in READ ignored.
REQ-025 Write and w_done in same cycle in FILL: write performed, then FULL.

Reset
REQ-026 rst in any state, including mid-read: state IDLE, skid buffer emptied, all outputs 0 next cycle; memory contents undefined, not cleared.

Configuration
REQ-027 Macro RESULT_READER_CNT_EN defined: extra output o_wr_count (ADDR_SIZE+1), accepted writes since last IDLE/FULL->FILL transition, saturating at 2**ADDR_SIZE, reset 0.
REQ-028 Macro undefined: port o_wr_count absent, counter not built; all other behaviour identical.

Structure
REQ-029 FSM state encoding and skid depth constant live in the shared config package next to DATA_WIDTH/ADDR_SIZE defines.
REQ-030 One sub-module result_ram: simple dual-port, 1 write port, 1 registered read port, depth 2**ADDR_SIZE.

Verification
REQ-031 Write addr 0..3 data 5,6,7,8, w_done; rd_start base 0 len 4, rd_ready=1 -> data 5,6,7,8 on consecutive cycles, first valid 2 cycles after rd_start, last on 8, o_rd_done next cycle.
REQ-032 Same buffer, rd_ready toggled 1,0,0,1,... -> 5,6,7,8 delivered once each, in order, data stable during stalls.
REQ-033 ADDR_SIZE=4, write addr 14,15,0 data 1,2,3, w_done; read base 14 len 3 -> 1,2,3 (wrap).
REQ-034 Write during READ -> o_wr_err=1, target location unchanged on subsequent read.
REQ-035 rst asserted at second beat of 4-beat read -> o_rd_valid, o_rd_busy, o_buf_ready 0 next cycle, state IDLE.
REQ-036 rd_start len 0 in FULL -> no o_rd_valid, o_rd_done pulse; with RESULT_READER_CNT_EN, 4 writes -> o_wr_count=4.
